// File: rtl/decoder_seq_pkg.sv
// Shared definitions for the registered one-hot decoder: mode codes,
// FSM state encoding and the counter sizing helper.
package decoder_pkg;

    localparam logic [1:0] MODE_LVL = 2'd0;
    localparam logic [1:0] MODE_PUL = 2'd1;
    localparam logic [1:0] MODE_SCN = 2'd2;
    localparam logic [1:0] MODE_OFF = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LVL  = 2'd1,
        PUL  = 2'd2,
        SCN  = 2'd3
    } state_e;

    // Counter must hold the larger of the pulse length and the dwell time.
    function automatic int cnt_width(input int pulse_len, input int dwell);
        int m;
        m = (pulse_len > dwell) ? pulse_len : dwell;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/decoder_seq_if.sv
// Control/status bundle of the decoder. The slave side is the decoder itself.
interface decoder_seq_if #(
    parameter int SEL_W = 3
);
    localparam int OUT_W = 1 << SEL_W;

    logic             en;
    logic [1:0]       mode;
    logic [SEL_W-1:0] sel;
    logic             load;
    logic             ready;
    logic [OUT_W-1:0] out;
    logic [SEL_W-1:0] idx;
    logic             busy;

    modport master (
        output en, mode, sel, load,
        input  ready, out, idx, busy
    );

    modport slave (
        input  en, mode, sel, load,
        output ready, out, idx, busy
    );

endinterface

// File: rtl/decoder_seq_onehot_dec.sv
// Combinational SEL_W-to-2^SEL_W one-hot decoder with enable.
module onehot_dec #(
    parameter int SEL_W = 3,
    parameter int OUT_W = 1 << SEL_W
) (
    input  logic             en_i,
    input  logic [SEL_W-1:0] sel_i,
    output logic [OUT_W-1:0] dec_o
);

    // Every index 0..OUT_W-1 is reachable, so no out-of-range guard is needed.
    for (genvar i = 0; i < OUT_W; i++) begin : g_bit
        assign dec_o[i] = en_i && (sel_i == SEL_W'(i));
    end

endmodule

// File: rtl/decoder_seq.sv
// Registered one-hot decoder with LEVEL, PULSE (handshaked strobe) and
// SCAN (auto-rotating with dwell) modes. All outputs come from flops.
module decoder_seq
    import decoder_pkg::*;
#(
    parameter int SEL_W     = 3,
    parameter int PULSE_LEN = 3,
    parameter int DWELL     = 2
) (
    input  logic          clk,
    input  logic          rst,
    decoder_seq_if.slave  bus
);

    localparam int OUT_W = 1 << SEL_W;
    localparam int CNT_W = cnt_width(PULSE_LEN, DWELL);

    state_e           state_q, state_d;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;

    logic             dec_en;
    logic [SEL_W-1:0] dec_sel;
    logic [SEL_W-1:0] idx_nxt;
    logic             abort;

    // Natural SEL_W-bit overflow gives the OUT_W-1 -> 0 scan wrap.
    assign idx_nxt = idx_q + 1'b1;

    onehot_dec #(.SEL_W(SEL_W), .OUT_W(OUT_W)) u_dec (
        .en_i  (dec_en),
        .sel_i (dec_sel),
        .dec_o (out_d)
    );

    // Next-state: abort first, then per-state behaviour; decoder request is
    // steered here so the out register only ever loads a one-hot or zero word.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        ready_d = ready_q;
        dec_en  = 1'b0;
        dec_sel = idx_q;
        abort   = !bus.en || (bus.mode != mode_q);

        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            busy_d  = 1'b0;
            ready_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    idx_d   = '0;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                    case (bus.mode)
                        MODE_LVL: begin
                            state_d = LVL;
                            dec_en  = 1'b1;
                            dec_sel = bus.sel;
                            idx_d   = bus.sel;
                        end
                        MODE_PUL: begin
                            if (bus.load && ready_q) begin
                                state_d = PUL;
                                dec_en  = 1'b1;
                                dec_sel = bus.sel;
                                idx_d   = bus.sel;
                                busy_d  = 1'b1;
                                ready_d = 1'b0;
                                cnt_d   = CNT_W'(1);
                            end
                        end
                        MODE_SCN: begin
                            state_d = SCN;
                            dec_en  = 1'b1;
                            dec_sel = bus.sel;
                            idx_d   = bus.sel;
                            busy_d  = 1'b1;
                            cnt_d   = CNT_W'(1);
                        end
                        default: ;
                    endcase
                end
                LVL: begin
                    dec_en  = 1'b1;
                    dec_sel = bus.sel;
                    idx_d   = bus.sel;
                end
                PUL: begin
                    if (cnt_q == CNT_W'(PULSE_LEN)) begin
                        // Strobe done; ready returns next cycle, so a load
                        // seen on this edge is dropped.
                        state_d = IDLE;
                        cnt_d   = '0;
                        idx_d   = '0;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        dec_en  = 1'b1;
                        dec_sel = idx_q;
                    end
                end
                SCN: begin
                    dec_en = 1'b1;
                    if (cnt_q == CNT_W'(DWELL)) begin
                        cnt_d   = CNT_W'(1);
                        idx_d   = idx_nxt;
                        dec_sel = idx_nxt;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        dec_sel = idx_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers; mode is sampled every cycle for abort detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= MODE_LVL;
            cnt_q   <= '0;
            out_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            mode_q  <= bus.mode;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    assign bus.out   = out_q;
    assign bus.idx   = idx_q;
    assign bus.busy  = busy_q;
    assign bus.ready = ready_q;

endmodule
